pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` input 1, rising-edge clock; `reset` input 1, synchronous active-high reset.
REQ-002 `id_rs1` input 5: rs1 of the instruction in IF_ID.
REQ-003 `id_rs2` input 5: rs2 of the instruction in IF_ID.
REQ-004 `ex_rd` input 5: rd of the instruction in ID_EX.
REQ-005 `ex_memread` input 1: MemRead of the instruction in ID_EX.
REQ-006 `mem_branch_taken` input 1: taken branch resolved in EX_MEM, i.e. (BranchEq&Zero)|(BranchGt&Great).
REQ-007 `dmem_req` input 1: the EX_MEM instruction accesses data memory (MemRead|MemWrite).
REQ-008 `dmem_ready` input 1: data memory completes the access this cycle.
REQ-009 `pc_write` output 1: PC load enable.
REQ-010 `if_id_write` output 1: IF_ID load enable.
REQ-011 `pipe_hold` output 1: freeze ID_EX, EX_MEM and MEM_WB.
REQ-012 `id_ex_bubble` output 1: load zeroed control signals into ID_EX.
REQ-013 `if_id_flush`, `id_ex_flush`, `ex_mem_flush` outputs 1 each: squash the stage register at the next edge.
REQ-014 `mem_timeout` output 1: sticky memory-wait timeout error.
REQ-015 `state` output 2: current FSM state, for debug.
REQ-016 `stall_cnt` and `flush_cnt` outputs 32 each: performance counters.

Function
REQ-017 The FSM SHALL have two states, RUN=0 and MEM_WAIT=1; the state is registered and the control outputs are Mealy (decoded from state and inputs in the same cycle).
REQ-018 Default outputs: pc_write=1, if_id_write=1; pipe_hold, id_ex_bubble and all flushes = 0.
REQ-019 Priority SHALL be memory wait > branch flush > load-use.
REQ-020 Memory wait: in RUN with dmem_req=1 and dmem_ready=0, drive pc_write=0, if_id_write=0, pipe_hold=1; the next state is MEM_WAIT.
REQ-021 In MEM_WAIT, the hold outputs of REQ-020 SHALL stay asserted while dmem_ready=0.
REQ-022 In MEM_WAIT with dmem_ready=1: outputs revert to RUN decoding in that same cycle (branch and load-use rules apply), and the next state is RUN.
REQ-023 Wait counter: 4 bits, cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle with dmem_ready=0.
REQ-024 When the wait counter reaches WAIT_LIMIT-1 with dmem_ready still 0, mem_timeout SHALL set and hold until reset; the FSM keeps waiting and the counter saturates.
REQ-025 Branch flush: mem_branch_taken=1 with no memory hold SHALL assert all three flushes and pc_write=1 for exactly that cycle.
REQ-026 A branch that resolves during a memory hold SHALL be flushed in the release cycle, because EX_MEM stays frozen until then.
REQ-027 Load-use: ex_memread=1, ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2) SHALL give pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle.
REQ-028 Load-use together with a branch flush: the flush wins, id_ex_bubble=0 and pc_write=1.
REQ-029 ex_rd==0 SHALL never cause a stall.
REQ-030 Latency: every hazard response SHALL be combinational in the detection cycle; there are no extra bubble cycles.

Reset
REQ-031 While reset=1 at a rising edge: next state RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-032 Outputs follow RUN decoding after the reset edge.
REQ-033 Reset in MEM_WAIT SHALL abandon the wait unconditionally.
REQ-034 Inputs are ignored during the reset cycle for state-update purposes.

Configuration
REQ-035 Macro HAZARD_STATS_EN defined: stall_cnt increments by 1 on each cycle with pc_write=0, and flush_cnt increments by 1 on each branch-flush cycle; both are 32-bit, saturating at 0xFFFFFFFF, cleared by reset.
REQ-036 Macro HAZARD_STATS_EN undefined: the counters are not built, the stall_cnt and flush_cnt ports remain, and both are tied to 0.

Structure
REQ-037 Package hazard_pkg SHALL hold the state enum (RUN, MEM_WAIT) and the constant WAIT_LIMIT=16.
REQ-038 Sub-module hazard_stat_counter (a 32-bit saturating counter with enable and synchronous reset) SHALL be instantiated twice, under HAZARD_STATS_EN only.

Verification
REQ-039 Load-use: ex_memread=1, ex_rd=5, id_rs2=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; defaults on the next cycle; stall_cnt=1.
REQ-040 ex_rd=0 load: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, pc_write=1.
REQ-041 Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high -> state=MEM_WAIT for cycles 2-3, pipe_hold=1 for 3 cycles, state=RUN after the ready cycle; stall_cnt=3.
REQ-042 Branch during wait plus load-use: mem_branch_taken=1 while dmem_ready=0 for 2 cycles, then ready with load-use also present -> flushes asserted only in the ready cycle, id_ex_bubble=0; flush_cnt=1.
REQ-043 Timeout: dmem_req=1, dmem_ready=0 for 20 cycles -> mem_timeout rises after 16 wait cycles and stays 1; reset -> mem_timeout=0, state=RUN.
REQ-044 Macro off: repeat REQ-039 with HAZARD_STATS_EN undefined -> stall_cnt=flush_cnt=0 throughout.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding and the memory-wait timeout limit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } hazard_state_e;

  localparam int WAIT_LIMIT = 16;
  localparam int WAIT_CNT_W = 4;
  localparam int STAT_W     = 32;

  // Last counter value before the memory wait is declared stuck.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_LIMIT - 1);

endpackage

// File: rtl/hazard_stat_counter.sv
// 32-bit saturating event counter with enable and synchronous reset.
// Used for the optional hazard statistics (HAZARD_STATS_EN).
module hazard_stat_counter
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  output logic [STAT_W-1:0] count_o
);

  logic [STAT_W-1:0] count_q;
  logic [STAT_W-1:0] count_d;

  // Holds at all-ones so a long run never wraps back to a small value.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {STAT_W{1'b1}})) begin
      count_d = count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory wait, branch flush, load-use stall.
// Define HAZARD_STATS_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_memread,
  input  logic              mem_branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              pipe_hold,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_timeout,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  hazard_state_e         state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;

  logic mem_hold;
  logic load_use;
  logic branch_flush;

  // Register x0 is hardwired zero, so a load to it can never feed a consumer.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    mem_hold = 1'b0;
    unique case (state_q)
      RUN:      mem_hold = dmem_req && !dmem_ready;
      MEM_WAIT: mem_hold = !dmem_ready;
      default:  mem_hold = 1'b0;
    endcase
  end

  // A branch seen during a hold is still sitting in the frozen EX_MEM, so it
  // is picked up naturally in the release cycle.
  assign branch_flush = mem_branch_taken && !mem_hold;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    pipe_hold    = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (mem_hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (branch_flush) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          // Keep waiting after a timeout; the counter just parks at its limit.
          if (wait_cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign state       = state_q;

`ifdef HAZARD_STATS_EN
  hazard_stat_counter u_stall_counter (
    .clk     (clk),
    .reset   (reset),
    .en_i    (!pc_write),
    .count_o (stall_cnt)
  );

  hazard_stat_counter u_flush_counter (
    .clk     (clk),
    .reset   (reset),
    .en_i    (branch_flush),
    .count_o (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
